pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush generator for the 5-stage MIPS pipeline. It drives stall0/clr0/clr1/clr2 into the ID/EXE register and the matching stall/flush controls for PC, IF/ID and EXE/MEM. It resolves load-use hazards, multi-cycle divide occupancy, data-memory handshake waits and interrupt/eret redirects. It holds the divider FSM and the deferred-interrupt latch.

Parameters:
DIV_CYCLES, 33, cycles EXE is occupied by a div (must be >= 2)
CNT_W, 6, divide counter width (2^CNT_W > DIV_CYCLES)

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_uses_rs  in  1  the instruction in ID reads rs
ID_uses_rt  in  1  the instruction in ID reads rt
ID_EXE_load_type_data  in  4  nonzero means EXE holds a load
ID_EXE_wreg_data  in  1  EXE writes the RF
EXE_waddr  in  5  EXE destination register
ID_EXE_is_div_data  in  1  EXE holds div/divu
mem_req  in  1  MEM stage has a data access this cycle
mem_data_ok  in  1  data bus completes the access
irq  in  1  exception/interrupt request from CP0 (level)
eret  in  1  eret committing in MEM
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  clear IF/ID
stall0  out  1  hold ID/EXE
clr0  out  1  load-use bubble into ID/EXE
clr1  out  1  exception flush
clr2  out  1  eret flush
exe_mem_stall  out  1  hold EXE/MEM
exe_mem_flush  out  1  bubble into EXE/MEM
div_busy  out  1  divider occupied
div_done  out  1  one-cycle pulse: quotient valid this cycle

Behaviour:
- State: div_st {D_IDLE, D_BUSY, D_DONE}; div_cnt[CNT_W-1:0]; mem_wait flag; irq_pend flag. All state clears on a clk edge with rst_n=0.
- Outputs are combinational from state and inputs. In reset state with idle inputs, every output is 0.
- mem_busy = (mem_req | mem_wait) & ~mem_data_ok.
- mem_wait:
  - Set on mem_req & ~mem_data_ok.
  - Cleared on mem_data_ok.
  - An access in flight is never abandoned.
- irq_take = (irq | irq_pend) & ~mem_busy.
  - irq_pend is set on irq & mem_busy.
  - irq_pend is cleared on irq_take.
- Priority, highest first:
  1. irq_take: clr1=1, if_id_flush=1, exe_mem_flush=1, all stalls 0, div_st -> D_IDLE.
  2. eret (no irq_take): clr2=1, if_id_flush=1, stalls 0.
  3. mem_busy: pc_stall, if_id_stall, stall0, exe_mem_stall all 1. The divide counter keeps running.
  4. div: pc_stall, if_id_stall, stall0 = 1 and exe_mem_flush = 1 whenever the divide is occupied. Occupied means D_BUSY, or D_IDLE with ID_EXE_is_div_data.
  5. load-use: load in EXE, ID_EXE_wreg_data=1, EXE_waddr!=0, and (ID_uses_rs & ID_rs==EXE_waddr or ID_uses_rt & ID_rt==EXE_waddr). Result: pc_stall=1, if_id_stall=1, clr0=1, stall0=0.
- Divider FSM:
  - D_IDLE & ID_EXE_is_div_data & ~irq_take -> D_BUSY, with div_cnt = DIV_CYCLES-2.
  - D_BUSY decrements each cycle; at 0 -> D_DONE.
  - D_DONE: div_done=1, no div stall, releasing EXE. -> D_IDLE unless mem_busy, in which case it holds D_DONE with div_done held.
  - div_busy = (div_st==D_BUSY).
  - The div occupies EXE for exactly DIV_CYCLES cycles in total when no other stall intervenes.
- Simultaneous irq and eret: irq wins. eret is squashed by the flush.
- Reset asserted mid-divide or mid-wait: all state returns to idle on the next edge, and no pending irq survives.

Decomposition:
- Shared package pipe_ctrl_pkg holds the div_st encoding (2-bit localparams) and a load_type "none" constant (4'b0000).
- One natural sub-module: div_occupancy_fsm, which owns div_st/div_cnt and produces div_busy/div_done/div_stall.

Test Plan:
- Load-use: EXE holds lw to $5 (load_type=4'b0001, wreg=1, waddr=5), ID reads rs=5 -> pc_stall=1, if_id_stall=1, clr0=1, stall0=0 for exactly 1 cycle. The same case with waddr=0 gives no stall.
- Divide, DIV_CYCLES=33: is_div asserted at cycle 0 -> stall0=1 on cycles 0..31, div_done=1 on cycle 32, div_busy=1 on cycles 1..31.
- Memory wait: mem_req=1, mem_data_ok low for 4 cycles -> all four stalls 1 for 4 cycles. They drop in the cycle mem_data_ok=1.
- Deferred irq: irq pulse during the memory wait at cycle 2, data_ok at cycle 4 -> clr1=1 only at cycle 4 (exactly once); irq_pend is cleared after.
- irq+eret same cycle with divide at cnt=10 -> clr1=1, clr2=0, if_id_flush=1, exe_mem_flush=1. Next cycle div_busy=0.
- Reset mid-divide: rst_n=0 for 1 edge at cnt=20 -> next cycle all outputs 0 and div_busy=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: divider state and load-type constants.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned LDTYPE_W = 4;

  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_BUSY = 2'd1;
  localparam logic [1:0] DIV_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    D_IDLE = DIV_ST_IDLE,
    D_BUSY = DIV_ST_BUSY,
    D_DONE = DIV_ST_DONE
  } div_st_e;

  localparam logic [LDTYPE_W-1:0] LOAD_TYPE_NONE = 4'b0000;

  // True when an ID source operand is read and matches the given destination.
  function automatic logic reg_hit(input logic uses,
                                   input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/div_occupancy_fsm.sv
// Tracks how long a div/divu occupies EXE and flags the quotient-valid cycle.
module div_occupancy_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic is_div,
  input  logic irq_take,
  input  logic mem_busy,
  output logic div_busy_c,
  output logic div_done_c,
  output logic div_stall_c
);

  div_st_e          div_st_q, div_st_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_st_q  <= D_IDLE;
      div_cnt_q <= '0;
    end else begin
      div_st_q  <= div_st_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Cycle 0 is the idle cycle that sees the div, then DIV_CYCLES-2 busy cycles, then one done cycle.
  always_comb begin
    div_st_d    = div_st_q;
    div_cnt_d   = div_cnt_q;
    div_busy_c  = 1'b0;
    div_done_c  = 1'b0;
    div_stall_c = 1'b0;
    case (div_st_q)
      D_IDLE: begin
        div_stall_c = is_div;
        if (is_div && !irq_take) begin
          div_st_d  = D_BUSY;
          div_cnt_d = CNT_W'(DIV_CYCLES - 2);
        end
      end
      D_BUSY: begin
        div_busy_c  = 1'b1;
        div_stall_c = 1'b1;
        if (irq_take) begin
          div_st_d  = D_IDLE;
          div_cnt_d = '0;
        end else if (div_cnt_q <= CNT_W'(1)) begin
          div_st_d  = D_DONE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q - CNT_W'(1);
        end
      end
      D_DONE: begin
        div_done_c = 1'b1;
        // Quotient must stay presented until the stalled MEM access lets EXE advance.
        if (irq_take || !mem_busy) begin
          div_st_d = D_IDLE;
        end
      end
      default: begin
        div_st_d  = D_IDLE;
        div_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: redirects, memory waits, divide occupancy, load-use.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_W-1:0]    ID_rs,
  input  logic [REG_W-1:0]    ID_rt,
  input  logic                ID_uses_rs,
  input  logic                ID_uses_rt,
  input  logic [LDTYPE_W-1:0] ID_EXE_load_type_data,
  input  logic                ID_EXE_wreg_data,
  input  logic [REG_W-1:0]    EXE_waddr,
  input  logic                ID_EXE_is_div_data,
  input  logic                mem_req,
  input  logic                mem_data_ok,
  input  logic                irq,
  input  logic                eret,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                if_id_flush,
  output logic                stall0,
  output logic                clr0,
  output logic                clr1,
  output logic                clr2,
  output logic                exe_mem_stall,
  output logic                exe_mem_flush,
  output logic                div_busy,
  output logic                div_done
);

  logic mem_wait_q, mem_wait_d;
  logic irq_pend_q, irq_pend_d;
  logic mem_busy_c;
  logic irq_take_c;
  logic load_use_c;
  logic div_stall_c;
  logic div_busy_c;
  logic div_done_c;

  div_occupancy_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .is_div      (ID_EXE_is_div_data),
    .irq_take    (irq_take_c),
    .mem_busy    (mem_busy_c),
    .div_busy_c  (div_busy_c),
    .div_done_c  (div_done_c),
    .div_stall_c (div_stall_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wait_q <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      mem_wait_q <= mem_wait_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // An issued access stays outstanding until data_ok; an irq seen meanwhile is parked.
  always_comb begin
    mem_busy_c = (mem_req || mem_wait_q) && !mem_data_ok;
    irq_take_c = (irq || irq_pend_q) && !mem_busy_c;

    mem_wait_d = mem_wait_q;
    if (mem_data_ok) begin
      mem_wait_d = 1'b0;
    end else if (mem_req) begin
      mem_wait_d = 1'b1;
    end

    irq_pend_d = irq_pend_q;
    if (irq_take_c) begin
      irq_pend_d = 1'b0;
    end else if (irq && mem_busy_c) begin
      irq_pend_d = 1'b1;
    end

    load_use_c = (ID_EXE_load_type_data != LOAD_TYPE_NONE) && ID_EXE_wreg_data &&
                 (EXE_waddr != '0) &&
                 (reg_hit(ID_uses_rs, ID_rs, EXE_waddr) || reg_hit(ID_uses_rt, ID_rt, EXE_waddr));
  end

  // Strict priority: interrupt, eret, memory wait, divide, load-use.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    stall0        = 1'b0;
    clr0          = 1'b0;
    clr1          = 1'b0;
    clr2          = 1'b0;
    exe_mem_stall = 1'b0;
    exe_mem_flush = 1'b0;
    div_busy      = div_busy_c;
    div_done      = div_done_c;
    if (irq_take_c) begin
      clr1          = 1'b1;
      if_id_flush   = 1'b1;
      exe_mem_flush = 1'b1;
    end else if (eret) begin
      clr2          = 1'b1;
      if_id_flush   = 1'b1;
    end else if (mem_busy_c) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      stall0        = 1'b1;
      exe_mem_stall = 1'b1;
    end else if (div_stall_c) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      stall0        = 1'b1;
      exe_mem_flush = 1'b1;
    end else if (load_use_c) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      clr0          = 1'b1;
    end
  end

endmodule
